// File: rtl/display_scan_mux_if.sv
// Bus between a display-word producer and the scan driver: word load, blanking
// control, and the per-slot digit outputs that feed the segment decoder.
interface display_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] data_in;
  logic                  load;
  logic                  lz_en;
  logic [3:0]            palabra;
  logic [N_DIGITS-1:0]   anodo;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_start;
  logic                  pending;

  modport master (
    output data_in, load, lz_en,
    input  palabra, anodo, digit_idx, frame_start, pending
  );

  modport slave (
    input  data_in, load, lz_en,
    output palabra, anodo, digit_idx, frame_start, pending
  );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment scan driver with a double-buffered
// display word, per-slot dead time and optional leading-zero blanking.
module display_scan_mux #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst,
  display_scan_mux_if.slave  bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int W_W   = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [W_W-1:0]   r_disp;
  logic [W_W-1:0]   r_buf;
  logic             r_pend;

  logic             w_slot_end;
  logic             w_commit;
  logic             w_dead;
  logic [3:0]       w_nib [N_DIGITS];
  logic [N_DIGITS-1:0] w_upper_nz;
  logic [N_DIGITS-1:0] w_blank;
  logic [N_DIGITS-1:0] w_sel;

  assign w_slot_end = (r_cnt == CNT_LAST);
  // Word swaps only at the very end of a frame so a frame never shows two words.
  assign w_commit   = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_disp <= '0;
      r_buf  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_commit && r_pend) begin
        r_disp <= r_buf;
      end

      // A load in the commit cycle refills the buffer after the old word moved out.
      if (bus.load) begin
        r_buf  <= bus.data_in;
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
    end
  end

  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_cnt < CNT_W'(DEAD_CYCLES));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign w_nib[gi]      = r_disp[4*gi +: 4];
      assign w_upper_nz[gi] = |r_disp[W_W-1:4*gi];
      assign w_sel[gi]      = (r_idx == IDX_W'(gi));
      if (gi == 0) begin : g_first
        assign w_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank[gi] = bus.lz_en & ~w_upper_nz[gi];
      end
      assign bus.anodo[gi] = ~(w_sel[gi] & ~w_dead & ~w_blank[gi]);
    end
  endgenerate

  assign bus.palabra     = w_nib[r_idx];
  assign bus.digit_idx   = r_idx;
  assign bus.pending     = r_pend;
  assign bus.frame_start = ~rst & (r_cnt == '0) & (r_idx == '0);
endmodule
